// File: rtl/io_ram_arbiter_pkg.sv
// Shared types and constants for the io/ram port arbiter.
//   state_e   : transaction phase encoding (IDLE, ACCESS, RESP)
//   M0/M1     : master index constants used for sel/last_grant
//   bus_pay_t : registered bus payload driven towards the datapath
package io_ram_arbiter_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 2;
    localparam int unsigned BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [CTRL_W-1:0] mem_ctrl;
    } bus_pay_t;

endpackage

// File: rtl/io_ram_arbiter_if.sv
// Interfaces around the arbiter.
//   io_ram_req_if : one requester (req/addr/wd/we/mem_ctrl in, ack/rd out)
//   io_ram_bus_if : shared datapath port (address/wd/we/mem_ctrl out, rd in)
interface io_ram_req_if;
    import io_ram_arbiter_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic              we;
    logic [CTRL_W-1:0] mem_ctrl;
    logic              ack;
    logic [DATA_W-1:0] rd;

    modport master (output req, addr, wd, we, mem_ctrl, input ack, rd);
    modport slave  (input req, addr, wd, we, mem_ctrl, output ack, rd);
endinterface

interface io_ram_bus_if;
    import io_ram_arbiter_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wd;
    logic              we;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [DATA_W-1:0] rd;

    modport master (output address, wd, we, mem_ctrl, input rd);
    modport slave  (input address, wd, we, mem_ctrl, output rd);
endinterface

// File: rtl/io_ram_arb_pick.sv
// Combinational winner select between two requesters.
//   req0_i/req1_i : request lines of m0/m1
//   last_grant_i  : master that completed the previous transaction
//   burst_cnt_i   : consecutive completions by last_grant_i (saturating)
//   winner_c      : chosen master, meaningful only when a request is high
module io_ram_arb_pick
    import io_ram_arbiter_pkg::*;
#(
    parameter bit          RR_ENABLE = 1'b1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               req0_i,
    input  logic               req1_i,
    input  logic               last_grant_i,
    input  logic [BURST_W-1:0] burst_cnt_i,
    output logic               winner_c
);

    logic both_c;
    logic base_c;

    // Base choice, then hand the grant away once the holder hits its burst limit.
    always_comb begin
        both_c = req0_i && req1_i;
        if (both_c) begin
            base_c = RR_ENABLE ? ~last_grant_i : M0;
        end else begin
            base_c = req0_i ? M0 : M1;
        end
        winner_c = base_c;
        if (both_c && (base_c == last_grant_i) && (burst_cnt_i == BURST_W'(MAX_BURST))) begin
            winner_c = ~base_c;
        end
    end

endmodule

// File: rtl/io_ram_arbiter.sv
// Two-master arbiter for the single io/ram datapath port. Each request runs
// IDLE (arbitrate) -> ACCESS (bus driven, we pulse, rd captured) -> RESP (ack).
//   clk, rst_n : clock, asynchronous active-low reset
//   m0, m1     : requester ports (m0 = CPU LSU, m1 = boot loader / debug)
//   bus        : datapath port; address/wd/mem_ctrl/we registered, rd sampled
//   busy       : high while in ACCESS or RESP
module io_ram_arbiter
    import io_ram_arbiter_pkg::*;
#(
    parameter bit          RR_ENABLE = 1'b1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    io_ram_req_if.slave   m0,
    io_ram_req_if.slave   m1,
    io_ram_bus_if.master  bus,
    output logic          busy
);

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic               last_q, last_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    bus_pay_t           pay_q, pay_d;
    logic               we_q, we_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic [DATA_W-1:0]  rd0_q, rd0_d;
    logic [DATA_W-1:0]  rd1_q, rd1_d;
    logic               busy_q, busy_d;
    logic               winner_c;

    io_ram_arb_pick #(
        .RR_ENABLE (RR_ENABLE),
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .req0_i       (m0.req),
        .req1_i       (m1.req),
        .last_grant_i (last_q),
        .burst_cnt_i  (burst_q),
        .winner_c     (winner_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        burst_d = burst_q;
        pay_d   = pay_q;
        we_d    = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;

        unique case (state_q)
            IDLE: begin
                if (m0.req || m1.req) begin
                    sel_d = winner_c;
                    if (winner_c == M1) begin
                        pay_d = '{addr: m1.addr, wd: m1.wd, mem_ctrl: m1.mem_ctrl};
                        we_d  = m1.we;
                    end else begin
                        pay_d = '{addr: m0.addr, wd: m0.wd, mem_ctrl: m0.mem_ctrl};
                        we_d  = m0.we;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // rd is captured even for writes; the requester ignores it then.
                if (sel_q == M1) begin
                    rd1_d  = bus.rd;
                    ack1_d = 1'b1;
                end else begin
                    rd0_d  = bus.rd;
                    ack0_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (sel_q == last_q) begin
                    if (burst_q != BURST_W'(MAX_BURST)) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                end else begin
                    burst_d = BURST_W'(1);
                    last_d  = sel_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset also kills an in-flight we pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= M0;
            last_q  <= M1;
            burst_q <= '0;
            pay_q   <= '0;
            we_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            pay_q   <= pay_d;
            we_q    <= we_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.address  = pay_q.addr;
    assign bus.wd       = pay_q.wd;
    assign bus.mem_ctrl = pay_q.mem_ctrl;
    assign bus.we       = we_q;
    assign m0.ack       = ack0_q;
    assign m1.ack       = ack1_q;
    assign m0.rd        = rd0_q;
    assign m1.rd        = rd1_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_io_ram_arbiter.sv
// Bench for io_ram_arbiter: a round-robin instance checked every cycle against
// a transaction-level model, plus a fixed-priority MAX_BURST=2 instance used
// for the burst-limit grant order.
module tb_io_ram_arbiter;
    import io_ram_arbiter_pkg::*;

    localparam int unsigned RR_MAX = 4;
    localparam int unsigned FP_MAX = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    io_ram_req_if m0_rr ();
    io_ram_req_if m1_rr ();
    io_ram_req_if m0_fp ();
    io_ram_req_if m1_fp ();
    io_ram_bus_if bus_rr ();
    io_ram_bus_if bus_fp ();
    logic busy_rr, busy_fp;

    io_ram_arbiter #(.RR_ENABLE(1'b1), .MAX_BURST(RR_MAX)) dut_rr (
        .clk(clk), .rst_n(rst_n), .m0(m0_rr), .m1(m1_rr), .bus(bus_rr), .busy(busy_rr)
    );
    io_ram_arbiter #(.RR_ENABLE(1'b0), .MAX_BURST(FP_MAX)) dut_fp (
        .clk(clk), .rst_n(rst_n), .m0(m0_fp), .m1(m1_fp), .bus(bus_fp), .busy(busy_fp)
    );

    // Datapath stand-in: 16-word RAM with combinational read.
    logic [31:0] ram [16] = '{0: 32'hDEADBEEF, default: 32'h0};
    always @(posedge clk) if (bus_rr.we) ram[bus_rr.address[5:2]] <= bus_rr.wd;
    assign bus_rr.rd = ram[bus_rr.address[5:2]];
    assign bus_fp.rd = bus_fp.address;

    // Reference model: one transaction in flight, age = cycles since grant.
    typedef struct {
        logic        m;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic [1:0]  ctrl;
    } txn_t;

    int          age;
    txn_t        cur;
    logic        last_m;
    int          run;
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rd [2];
    bit          rd_known [2];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        age         = 0;
        cur         = '{m: M0, addr: '0, wd: '0, we: 1'b0, ctrl: '0};
        last_m      = M1;
        run         = 0;
        exp_rd[0]   = '0;
        exp_rd[1]   = '0;
        rd_known[0] = 1'b1;
        rd_known[1] = 1'b1;
    endtask

    function automatic logic pick(input logic r0, input logic r1);
        logic w;
        if (!(r0 && r1)) return r0 ? M0 : M1;
        w = !last_m;
        if (w == last_m && run >= int'(RR_MAX)) w = !w;
        return w;
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic mdl_step();
        logic w;
        if (age == 0) begin
            if (m0_rr.req || m1_rr.req) begin
                w = pick(m0_rr.req, m1_rr.req);
                if (w == M1) cur = '{m: M1, addr: m1_rr.addr, wd: m1_rr.wd, we: m1_rr.we, ctrl: m1_rr.mem_ctrl};
                else         cur = '{m: M0, addr: m0_rr.addr, wd: m0_rr.wd, we: m0_rr.we, ctrl: m0_rr.mem_ctrl};
                if (w == last_m) begin
                    if (run < int'(RR_MAX)) run++;
                end else begin
                    run    = 1;
                    last_m = w;
                end
                age = 1;
            end
        end else if (age == 1) begin
            if (cur.we) ref_mem[cur.addr[5:2]] = cur.wd;
            else        exp_rd[cur.m] = ref_mem[cur.addr[5:2]];
            rd_known[cur.m] = !cur.we;
            age = 2;
        end else begin
            age = 0;
        end
    endtask

    task automatic check_outputs();
        chk("busy",     32'(busy_rr),          32'(age != 0));
        chk("we",       32'(bus_rr.we),        32'(age == 1 && cur.we));
        chk("address",  bus_rr.address,        cur.addr);
        chk("wd",       bus_rr.wd,             cur.wd);
        chk("mem_ctrl", 32'(bus_rr.mem_ctrl),  32'(cur.ctrl));
        chk("m0_ack",   32'(m0_rr.ack),        32'(age == 2 && cur.m == M0));
        chk("m1_ack",   32'(m1_rr.ack),        32'(age == 2 && cur.m == M1));
        if (rd_known[0]) chk("m0_rd", m0_rr.rd, exp_rd[0]);
        if (rd_known[1]) chk("m1_rd", m1_rr.rd, exp_rd[1]);
    endtask

    task automatic tick();
        mdl_step();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic bit ack_exp(input logic m);
        return age == 2 && cur.m == m;
    endfunction

    task automatic drive(input logic m, input logic req, input logic [31:0] addr,
                         input logic [31:0] wd, input logic we, input logic [1:0] ctrl);
        if (m == M1) begin
            m1_rr.req = req; m1_rr.addr = addr; m1_rr.wd = wd; m1_rr.we = we; m1_rr.mem_ctrl = ctrl;
        end else begin
            m0_rr.req = req; m0_rr.addr = addr; m0_rr.wd = wd; m0_rr.we = we; m0_rr.mem_ctrl = ctrl;
        end
    endtask

    task automatic drop(input logic m);
        if (m == M1) m1_rr.req = 1'b0;
        else         m0_rr.req = 1'b0;
    endtask

    task automatic drive_rand(input logic m);
        drive(m, 1'b1, $urandom() & 32'hFFFF_FFFC, $urandom(),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    endtask

    logic rr_order [$];
    logic fp_order [$];
    logic exp_rr [6] = '{M0, M1, M0, M1, M0, M1};
    logic exp_fp [6] = '{M0, M0, M1, M0, M0, M1};
    int   acks_seen, cyc, prev_ack;
    logic oq;

    initial begin
        rst_n = 1'b0;
        drive(M0, 1'b0, '0, '0, 1'b0, '0);
        drive(M1, 1'b0, '0, '0, 1'b0, '0);
        m0_fp.req = 1'b0; m0_fp.addr = 32'h100; m0_fp.wd = '0; m0_fp.we = 1'b0; m0_fp.mem_ctrl = 2'd2;
        m1_fp.req = 1'b0; m1_fp.addr = 32'h104; m1_fp.wd = '0; m1_fp.we = 1'b0; m1_fp.mem_ctrl = 2'd1;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        ref_mem[0] = 32'hDEADBEEF;
        mdl_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs();
        chk("fp_busy_reset",    32'(busy_fp),        32'h0);
        chk("fp_address_reset", bus_fp.address,      32'h0);
        chk("fp_ack_reset",     32'({m0_fp.ack, m1_fp.ack}), 32'h0);
        rst_n = 1'b1;

        // Contention from reset: both held on both instances
        drive(M0, 1'b1, 32'h100, 32'h0, 1'b0, 2'd2);
        drive(M1, 1'b1, 32'h104, 32'h11, 1'b0, 2'd1);
        m0_fp.req = 1'b1;
        m1_fp.req = 1'b1;
        acks_seen = 0; cyc = 0; prev_ack = -1;
        while (acks_seen < 6 && cyc < 40) begin
            tick();
            cyc++;
            if (age == 2) acks_seen++;
            if (m0_rr.ack || m1_rr.ack) begin
                rr_order.push_back(m1_rr.ack);
                if (prev_ack < 0) chk("first_ack_cycle", 32'(cyc), 32'd2);
                else              chk("ack_gap", 32'(cyc - prev_ack), 32'd3);
                prev_ack = cyc;
            end
            if (m0_fp.ack || m1_fp.ack) fp_order.push_back(m1_fp.ack);
        end
        drop(M0); drop(M1);
        m0_fp.req = 1'b0;
        m1_fp.req = 1'b0;
        chk("rr_count", 32'(rr_order.size()), 32'd6);
        chk("fp_count", 32'(fp_order.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            oq = (i < rr_order.size()) ? rr_order[i] : 1'bx;
            chk($sformatf("rr_order[%0d]", i), 32'(oq), 32'(exp_rr[i]));
            oq = (i < fp_order.size()) ? fp_order[i] : 1'bx;
            chk($sformatf("fp_order[%0d]", i), 32'(oq), 32'(exp_fp[i]));
        end
        tick();
        tick();

        // Single read by m0
        drive(M0, 1'b1, 32'h100, 32'h1234_5678, 1'b0, 2'd2);
        tick();
        chk("read_address", bus_rr.address, 32'h100);
        chk("read_we",      32'(bus_rr.we), 32'h0);
        tick();
        chk("read_ack", 32'(m0_rr.ack), 32'h1);
        chk("read_rd",  m0_rr.rd,       32'hDEADBEEF);
        drop(M0);
        tick();

        // Single write by m1 to the LED word
        drive(M1, 1'b1, 32'h0000_7F04, 32'h0000_00A5, 1'b1, 2'd0);
        tick();
        chk("write_we_access", 32'(bus_rr.we), 32'h1);
        chk("write_wd",        bus_rr.wd,      32'h0000_00A5);
        tick();
        chk("write_we_resp", 32'(bus_rr.we),  32'h0);
        chk("write_m1_ack",  32'(m1_rr.ack),  32'h1);
        chk("write_m0_ack",  32'(m0_rr.ack),  32'h0);
        drop(M1);
        tick();

        // Request dropped during ACCESS still completes
        drive(M0, 1'b1, 32'h0000_7F04, 32'h0, 1'b0, 2'd1);
        tick();
        drop(M0);
        tick();
        chk("drop_ack", 32'(m0_rr.ack), 32'h1);
        chk("drop_rd",  m0_rr.rd,       32'h0000_00A5);
        tick();
        tick();
        chk("drop_idle_busy", 32'(busy_rr), 32'h0);

        // Asynchronous reset during ACCESS of a write
        drive(M1, 1'b1, 32'h108, 32'h5A5A_5A5A, 1'b1, 2'd3);
        tick();
        chk("pre_reset_we", 32'(bus_rr.we), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we",   32'(bus_rr.we), 32'h0);
        chk("async_busy", 32'(busy_rr),   32'h0);
        drop(M1);
        mdl_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        drive(M0, 1'b1, 32'h108, 32'h0, 1'b0, 2'd2);
        tick();
        tick();
        chk("post_reset_ack", 32'(m0_rr.ack), 32'h1);
        chk("post_reset_rd",  m0_rr.rd,       32'h0);
        drop(M0);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (ack_exp(1'(k))) begin
                    if ($urandom_range(0, 1) == 1) drive_rand(1'(k));
                    else                            drop(1'(k));
                end else if (((k == 0) ? m0_rr.req : m1_rr.req) == 1'b0 && $urandom_range(0, 2) == 0) begin
                    drive_rand(1'(k));
                end
            end
            tick();
        end
        drop(M0);
        drop(M1);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/io_ram_arbiter.md
Name: io_ram_arbiter

Overview:
- Shares the single io/ram datapath port (address, wd, we, mem_ctrl, rd) between two requesters: m0 is the CPU load/store unit and m1 is the UART boot loader / debug master.
- Each request is serialized into a fixed three-phase transaction: arbitrate, access, respond.
- The write enable reaching RAM, UART or LED is a single-cycle pulse, so peripheral side effects happen exactly once.
- Sits between the core/debug masters and io_ram_datapath.

Parameters:
- RR_ENABLE, 1, 1 = round-robin between m0/m1; 0 = fixed priority with m0 always winning ties.
- MAX_BURST, 4, maximum consecutive grants to one master while the other is requesting. Range 1..15; 0 is illegal.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- m0_req  input  1  m0 request; held high until m0_ack
- m0_addr  input  32  m0 byte address
- m0_wd  input  32  m0 write data
- m0_we  input  1  m0 write (1) / read (0)
- m0_mem_ctrl  input  2  m0 access size code, passed through
- m0_ack  output  1  one-cycle completion pulse to m0
- m0_rd  output  32  m0 read data; valid while m0_ack=1, held until the next m0 ack
- m1_req, m1_addr, m1_wd, m1_we, m1_mem_ctrl, m1_ack, m1_rd: identical to the m0 set, for m1
- address  output  32  to datapath
- wd  output  32  to datapath
- we  output  1  to datapath; pulse only
- mem_ctrl  output  2  to datapath
- rd  input  32  from datapath; combinational read of the current address
- busy  output  1  high in ACCESS and RESP

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=m1 (so m0 wins the first tie), burst_cnt=0.
  - All outputs 0, including address, wd, mem_ctrl, we, acks, m*_rd and busy.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner:
    - Only one request high: that master wins.
    - Both high, RR_ENABLE=1: winner = not last_grant.
    - Both high, RR_ENABLE=0: winner = m0.
    - Burst override: if both are high and winner == last_grant and burst_cnt == MAX_BURST, the other master wins instead.
  - Register the winner's addr/wd/we/mem_ctrl into the bus output registers, set sel=winner, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Bus outputs are stable from registers; we = registered we.
  - Capture rd into the selected master's rd register at the clock edge. Writes capture too; the value is don't-care.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - Pulse the selected master's ack. we=0. Bus address/wd/mem_ctrl hold their values.
  - Update last_grant: if sel == last_grant, burst_cnt++ (saturating at MAX_BURST); else burst_cnt=1 and last_grant=sel.
  - Go to IDLE.
- Latency and throughput:
  - req high at edge N (state IDLE) → bus driven in cycle N+1 → ack high in cycle N+2.
  - Minimum 3 cycles per transaction; back-to-back requests see ack every 3rd cycle.
- Requester protocol:
  - The master must hold req and its request fields stable until ack.
  - Request fields are sampled only in IDLE; changes after the grant are ignored.
  - If req drops during ACCESS/RESP, the transaction still completes and ack still pulses.
  - A master that keeps req high after ack starts a new request.
- The unselected master's ack stays 0 and its rd register is unchanged.
- Reset asserted mid-transaction: immediate return to the reset state. we drops asynchronously, and no ack is issued for the aborted transaction.
- mem_ctrl is passed through unmodified; the arbiter does no address decoding.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - master index constants: M0=1'b0, M1=1'b1
- One sub-module, io_ram_arb_pick: combinational winner select from req0, req1, last_grant, burst_cnt, RR_ENABLE and MAX_BURST.
- FSM, bus registers and rd capture stay in the top.

Test Plan:
- Single read: m0_req with m0_addr=0x100, we=0, rd model returns 0x DEADBEEF → address=0x100 in cycle N+1; m0_ack=1 and m0_rd=0xDEADBEEF in cycle N+2; we never high.
- Single write: m1 writes 0x0000_00A5 to the LED address → we high for exactly one cycle with wd=0xA5; m1_ack one cycle later; m0_ack stays 0.
- Contention, RR_ENABLE=1: both requests held continuously from reset → grants alternate m0, m1, m0, m1; acks 3 cycles apart.
- Burst limit: RR_ENABLE=0, MAX_BURST=2, both held → grant order m0, m0, m1, m0, m0, m1.
- Async reset: assert rst_n=0 during ACCESS of a write → we falls without a clock edge; after release state is IDLE, no ack, and the next request completes normally.
- Request drop: m0_req deasserted in the ACCESS cycle → m0_ack still pulses once, then the arbiter stays in IDLE with busy=0.
